ascii2scan: RTL and testbench

ASCII2SCAN -- requirements
Module: ascii2scan

---
 rtl/ps2_pkg.sv | 48 ++++
 rtl/ascii2scan_lut.sv | 82 ++++++++
 rtl/ascii2scan.sv | 90 +++++++++
 tb/tb_ascii2scan.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ============================================================================
// Module  : ps2_pkg
// Purpose : PS/2 set-2 scan-code constants and the encoder state encoding.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package ps2_pkg;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SH_MK   = 3'd1,
    KEY_MK  = 3'd2,
    KEY_F0  = 3'd3,
    KEY_BRK = 3'd4,
    SH_F0   = 3'd5,
    SH_BRK  = 3'd6
  } state_t;

  // Successor taken on a transfer; shifted characters wrap the key bytes in shift make/break.
  function automatic state_t next_state(input state_t st, input logic shifted);
    case (st)
      SH_MK:   next_state = KEY_MK;
      KEY_MK:  next_state = KEY_F0;
      KEY_F0:  next_state = KEY_BRK;
      KEY_BRK: next_state = shifted ? SH_F0 : IDLE;
      SH_F0:   next_state = SH_BRK;
      default: next_state = IDLE;
    endcase
  endfunction

  function automatic logic [7:0] state_byte(input state_t st, input logic [7:0] code);
    case (st)
      SH_MK, SH_BRK:   state_byte = SC_LSHIFT;
      KEY_MK, KEY_BRK: state_byte = code;
      KEY_F0, SH_F0:   state_byte = SC_BREAK;
      default:         state_byte = 8'h00;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/ascii2scan_lut.sv
// ============================================================================
// Module  : ascii2scan_lut
// Purpose : Combinational US-layout ASCII to PS/2 set-2 key code table.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module ascii2scan_lut (
  input  logic [7:0] ascii,
  output logic [7:0] code,
  output logic       shift,
  output logic       valid
);

  logic [7:0] w_lower;
  logic       w_is_letter;

  assign w_lower     = ascii | 8'h20;
  assign w_is_letter = ((ascii >= 8'h41) && (ascii <= 8'h5A)) ||
                       ((ascii >= 8'h61) && (ascii <= 8'h7A));

  always_comb begin
    code  = 8'h00;
    shift = 1'b0;
    valid = 1'b1;
    if (w_is_letter) begin
      shift = (ascii <= 8'h5A);
      case (w_lower)
        8'h61: code = 8'h1C;  8'h62: code = 8'h32;  8'h63: code = 8'h21;
        8'h64: code = 8'h23;  8'h65: code = 8'h24;  8'h66: code = 8'h2B;
        8'h67: code = 8'h34;  8'h68: code = 8'h33;  8'h69: code = 8'h43;
        8'h6A: code = 8'h3B;  8'h6B: code = 8'h42;  8'h6C: code = 8'h4B;
        8'h6D: code = 8'h3A;  8'h6E: code = 8'h31;  8'h6F: code = 8'h44;
        8'h70: code = 8'h4D;  8'h71: code = 8'h15;  8'h72: code = 8'h2D;
        8'h73: code = 8'h1B;  8'h74: code = 8'h2C;  8'h75: code = 8'h3C;
        8'h76: code = 8'h2A;  8'h77: code = 8'h1D;  8'h78: code = 8'h22;
        8'h79: code = 8'h35;  8'h7A: code = 8'h1A;
        default: code = 8'h00;
      endcase
    end else begin
      case (ascii)
        8'h30: code = 8'h45;  8'h31: code = 8'h16;  8'h32: code = 8'h1E;
        8'h33: code = 8'h26;  8'h34: code = 8'h25;  8'h35: code = 8'h2E;
        8'h36: code = 8'h36;  8'h37: code = 8'h3D;  8'h38: code = 8'h3E;
        8'h39: code = 8'h46;
        8'h29: begin code = 8'h45; shift = 1'b1; end
        8'h21: begin code = 8'h16; shift = 1'b1; end
        8'h40: begin code = 8'h1E; shift = 1'b1; end
        8'h23: begin code = 8'h26; shift = 1'b1; end
        8'h24: begin code = 8'h25; shift = 1'b1; end
        8'h25: begin code = 8'h2E; shift = 1'b1; end
        8'h5E: begin code = 8'h36; shift = 1'b1; end
        8'h26: begin code = 8'h3D; shift = 1'b1; end
        8'h2A: begin code = 8'h3E; shift = 1'b1; end
        8'h28: begin code = 8'h46; shift = 1'b1; end
        8'h2D: code = 8'h4E;  8'h3D: code = 8'h55;  8'h5B: code = 8'h54;
        8'h5D: code = 8'h5B;  8'h5C: code = 8'h5D;  8'h3B: code = 8'h4C;
        8'h27: code = 8'h52;  8'h60: code = 8'h0E;  8'h2C: code = 8'h41;
        8'h2E: code = 8'h49;  8'h2F: code = 8'h4A;
        8'h5F: begin code = 8'h4E; shift = 1'b1; end
        8'h2B: begin code = 8'h55; shift = 1'b1; end
        8'h7B: begin code = 8'h54; shift = 1'b1; end
        8'h7D: begin code = 8'h5B; shift = 1'b1; end
        8'h7C: begin code = 8'h5D; shift = 1'b1; end
        8'h3A: begin code = 8'h4C; shift = 1'b1; end
        8'h22: begin code = 8'h52; shift = 1'b1; end
        8'h7E: begin code = 8'h0E; shift = 1'b1; end
        8'h3C: begin code = 8'h41; shift = 1'b1; end
        8'h3E: begin code = 8'h49; shift = 1'b1; end
        8'h3F: begin code = 8'h4A; shift = 1'b1; end
        8'h20: code = 8'h29;
        8'h09: code = 8'h0D;
        8'h7F, 8'h08: code = 8'h66;
        8'h0A, 8'h0D: code = 8'h5A;
        default: valid = 1'b0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/ascii2scan.sv
// ============================================================================
// Module  : ascii2scan
// Purpose : Encodes one ASCII character into its PS/2 set-2 make/break bytes.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module ascii2scan
  import ps2_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ascii,
  input  logic       asciirdy,
  output logic       busy,
  output logic [7:0] scan,
  output logic       scanrdy,
  input  logic       scanack,
  output logic       unmapped
);

  logic [7:0] w_code;
  logic       w_shift;
  logic       w_valid;
  state_t     w_next;

  state_t     r_state;
  logic [7:0] r_code;
  logic       r_shift;
  logic [7:0] r_scan;
  logic       r_scanrdy;
  logic       r_busy;
  logic       r_unmapped;

  ascii2scan_lut u_lut (
    .ascii (ascii),
    .code  (w_code),
    .shift (w_shift),
    .valid (w_valid)
  );

  assign w_next = next_state(r_state, r_shift);

  // Outputs are registered from the state being entered, so scan is valid the cycle after each edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_code     <= 8'h00;
      r_shift    <= 1'b0;
      r_scan     <= 8'h00;
      r_scanrdy  <= 1'b0;
      r_busy     <= 1'b0;
      r_unmapped <= 1'b0;
    end else begin
      r_unmapped <= 1'b0;
      case (r_state)
        IDLE: begin
          if (asciirdy) begin
            if (w_valid) begin
              r_code    <= w_code;
              r_shift   <= w_shift;
              r_state   <= w_shift ? SH_MK : KEY_MK;
              r_scan    <= w_shift ? SC_LSHIFT : w_code;
              r_scanrdy <= 1'b1;
              r_busy    <= 1'b1;
            end else begin
              r_unmapped <= 1'b1;
            end
          end
        end
        default: begin
          if (r_scanrdy && scanack) begin
            r_state   <= w_next;
            r_scan    <= state_byte(w_next, r_code);
            r_scanrdy <= (w_next != IDLE);
            r_busy    <= (w_next != IDLE);
          end
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign scan     = r_scan;
  assign scanrdy  = r_scanrdy;
  assign unmapped = r_unmapped;

endmodule

`default_nettype wire

// File: tb/tb_ascii2scan.sv
// ============================================================================
// Module  : tb_ascii2scan
// Purpose : Self-checking bench for ascii2scan against a table-driven model.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ascii2scan;

    typedef logic [7:0] bq_t[$];

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] ascii;
    logic       asciirdy;
    logic       busy;
    logic [7:0] scan;
    logic       scanrdy;
    logic       scanack;
    logic       unmapped;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] m_code [256];
    bit         m_shift[256];
    bit         m_valid[256];

    always #5 clk = ~clk;

    ascii2scan dut (
        .clk      (clk),
        .rst      (rst),
        .ascii    (ascii),
        .asciirdy (asciirdy),
        .busy     (busy),
        .scan     (scan),
        .scanrdy  (scanrdy),
        .scanack  (scanack),
        .unmapped (unmapped)
    );

    task automatic build_model();
        string      lc  = "abcdefghijklmnopqrstuvwxyz";
        string      dsh = ")!@#$%^&*(";
        string      pun = "-=[]x;'`,./";
        string      psh = "_+{}|:x~<>?";
        logic [7:0] lcodes[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                   8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                   8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                   8'h35, 8'h1A};
        logic [7:0] dcodes[10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                   8'h3E, 8'h46};
        logic [7:0] pcodes[11] = '{8'h4E, 8'h55, 8'h54, 8'h5B, 8'h5D, 8'h4C, 8'h52, 8'h0E,
                                   8'h41, 8'h49, 8'h4A};
        pun.putc(4, 8'h5C);
        psh.putc(6, 8'h22);
        for (int i = 0; i < 256; i++) begin
            m_code[i] = 8'h00; m_shift[i] = 1'b0; m_valid[i] = 1'b0;
        end
        for (int i = 0; i < 26; i++) begin
            m_code[lc[i]] = lcodes[i];       m_valid[lc[i]] = 1'b1;
            m_code[lc[i] - 32] = lcodes[i];  m_valid[lc[i] - 32] = 1'b1; m_shift[lc[i] - 32] = 1'b1;
        end
        for (int i = 0; i < 10; i++) begin
            m_code[48 + i] = dcodes[i];      m_valid[48 + i] = 1'b1;
            m_code[dsh[i]] = dcodes[i];      m_valid[dsh[i]] = 1'b1;      m_shift[dsh[i]] = 1'b1;
        end
        for (int i = 0; i < 11; i++) begin
            m_code[pun[i]] = pcodes[i];      m_valid[pun[i]] = 1'b1;
            m_code[psh[i]] = pcodes[i];      m_valid[psh[i]] = 1'b1;      m_shift[psh[i]] = 1'b1;
        end
        m_code[8'h20] = 8'h29; m_valid[8'h20] = 1'b1;
        m_code[8'h09] = 8'h0D; m_valid[8'h09] = 1'b1;
        m_code[8'h7F] = 8'h66; m_valid[8'h7F] = 1'b1;
        m_code[8'h08] = 8'h66; m_valid[8'h08] = 1'b1;
        m_code[8'h0A] = 8'h5A; m_valid[8'h0A] = 1'b1;
        m_code[8'h0D] = 8'h5A; m_valid[8'h0D] = 1'b1;
    endtask

    function automatic string seq_str(input bq_t q);
        string s = "";
        foreach (q[i]) s = {s, $sformatf("%02h ", q[i])};
        return s;
    endfunction

    function automatic string exp_str(input logic [7:0] ch);
        if (!m_valid[ch]) return "";
        if (m_shift[ch]) return $sformatf("12 %02h f0 %02h f0 12 ", m_code[ch], m_code[ch]);
        return $sformatf("%02h f0 %02h ", m_code[ch], m_code[ch]);
    endfunction

    // Offers one character, then plays the sink until the encoder goes idle.
    // ackpct < 0 selects a fixed pattern: three stalled cycles before each accept.
    task automatic collect(input logic [7:0] ch, input int ackpct, input int inject_at,
                           output bq_t got, output int busy_cyc, output int hold_err,
                           output int unm, output bit timeout);
        logic [7:0] held = 8'h00;
        bit         holding = 1'b0;
        bit         ack;
        int         wait_n = 0;
        got = {}; busy_cyc = 0; hold_err = 0; unm = 0; timeout = 1'b1;
        ascii = ch; asciirdy = 1'b1;
        @(negedge clk);
        asciirdy = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (unmapped) unm++;
            if (busy) busy_cyc++;
            if (!busy && !scanrdy) begin
                timeout = 1'b0;
                break;
            end
            ascii    = (k == inject_at) ? 8'h62 : 8'($urandom_range(0, 255));
            asciirdy = (k == inject_at);
            if (scanrdy) begin
                if (holding && scan !== held) hold_err++;
                ack = (ackpct < 0) ? (wait_n == 3) : ($urandom_range(0, 99) < ackpct);
                scanack = ack;
                if (ack) begin
                    got.push_back(scan); holding = 1'b0; wait_n = 0;
                end else begin
                    holding = 1'b1; held = scan; wait_n++;
                end
            end else begin
                scanack = 1'b0;
            end
            @(negedge clk);
        end
        scanack = 1'b0; asciirdy = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; ascii = 8'h00; asciirdy = 1'b0; scanack = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++; if (busy !== 1'b0)     begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_vec++; if (scanrdy !== 1'b0)  begin n_err++; $display("FAIL reset_scanrdy got %b want 0", scanrdy); end
        n_vec++; if (scan !== 8'h00)    begin n_err++; $display("FAIL reset_scan got %h want 00", scan); end
        n_vec++; if (unmapped !== 1'b0) begin n_err++; $display("FAIL reset_unmapped got %b want 0", unmapped); end
        rst = 1'b0;
    endtask

    task automatic test_lower_a();
        bq_t got; int bc, he, un; bit to;
        collect(8'h61, 100, -1, got, bc, he, un, to);
        n_vec++; if (to || seq_str(got) != "1c f0 1c ")
            begin n_err++; $display("FAIL lower_a_seq got '%s' want '1c f0 1c '", seq_str(got)); end
        n_vec++; if (bc != 3) begin n_err++; $display("FAIL lower_a_busy got %0d want 3", bc); end
    endtask

    task automatic test_upper_a();
        bq_t got; int bc, he, un; bit to;
        collect(8'h41, 100, -1, got, bc, he, un, to);
        n_vec++; if (to || seq_str(got) != "12 1c f0 1c f0 12 ")
            begin n_err++; $display("FAIL upper_a_seq got '%s' want '12 1c f0 1c f0 12 '", seq_str(got)); end
        n_vec++; if (bc != 6) begin n_err++; $display("FAIL upper_a_busy got %0d want 6", bc); end
    endtask

    task automatic test_backpressure();
        bq_t got; int bc, he, un; bit to;
        collect(8'h21, -1, -1, got, bc, he, un, to);
        n_vec++; if (to || seq_str(got) != "12 16 f0 16 f0 12 ")
            begin n_err++; $display("FAIL bp_seq got '%s' want '12 16 f0 16 f0 12 '", seq_str(got)); end
        n_vec++; if (bc != 24) begin n_err++; $display("FAIL bp_busy got %0d want 24", bc); end
        n_vec++; if (he != 0)  begin n_err++; $display("FAIL bp_hold got %0d want 0", he); end
    endtask

    task automatic test_unmapped();
        logic [7:0] chs[2] = '{8'h01, 8'h80};
        foreach (chs[i]) begin
            ascii = chs[i]; asciirdy = 1'b1;
            @(negedge clk);
            asciirdy = 1'b0;
            n_vec++; if (unmapped !== 1'b1) begin n_err++; $display("FAIL unm_pulse got %b want 1", unmapped); end
            n_vec++; if (busy !== 1'b0 || scanrdy !== 1'b0)
                begin n_err++; $display("FAIL unm_idle got busy=%b rdy=%b want 0 0", busy, scanrdy); end
            @(negedge clk);
            n_vec++; if (unmapped !== 1'b0 || busy !== 1'b0 || scanrdy !== 1'b0)
                begin n_err++; $display("FAIL unm_after got u=%b b=%b r=%b want 0 0 0", unmapped, busy, scanrdy); end
        end
    endtask

    task automatic test_ignore_busy();
        bq_t got; int bc, he, un; bit to;
        collect(8'h61, 100, 1, got, bc, he, un, to);
        n_vec++; if (to || seq_str(got) != "1c f0 1c ")
            begin n_err++; $display("FAIL ignore_seq got '%s' want '1c f0 1c '", seq_str(got)); end
        @(negedge clk);
        n_vec++; if (busy !== 1'b0 || scanrdy !== 1'b0)
            begin n_err++; $display("FAIL ignore_idle got busy=%b rdy=%b want 0 0", busy, scanrdy); end
    endtask

    task automatic test_reset_mid();
        bq_t got; int bc, he, un; bit to;
        ascii = 8'h41; asciirdy = 1'b1;
        @(negedge clk);
        asciirdy = 1'b0; scanack = 1'b1;
        repeat (2) @(negedge clk);
        scanack = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_vec++; if (busy !== 1'b0 || scanrdy !== 1'b0 || scan !== 8'h00 || unmapped !== 1'b0)
            begin n_err++; $display("FAIL rstmid_out got b=%b r=%b s=%h u=%b want 0 0 00 0", busy, scanrdy, scan, unmapped); end
        @(negedge clk);
        rst = 1'b0;
        collect(8'h0A, 100, -1, got, bc, he, un, to);
        n_vec++; if (to || seq_str(got) != "5a f0 5a ")
            begin n_err++; $display("FAIL rstmid_seq got '%s' want '5a f0 5a '", seq_str(got)); end
    endtask

    task automatic test_random();
        bq_t got; int bc, he, un; bit to;
        logic [7:0] ch;
        for (int n = 0; n < 80; n++) begin
            ch = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(32, 126)) : 8'($urandom_range(0, 255));
            collect(ch, int'($urandom_range(25, 100)), -1, got, bc, he, un, to);
            n_vec++; if (to || seq_str(got) != exp_str(ch))
                begin n_err++; $display("FAIL rand_seq ch=%h got '%s' want '%s'", ch, seq_str(got), exp_str(ch)); end
            n_vec++; if (un != (m_valid[ch] ? 0 : 1) || he != 0)
                begin n_err++; $display("FAIL rand_flags ch=%h got unm=%0d hold=%0d want unm=%0d hold=0", ch, un, he, m_valid[ch] ? 0 : 1); end
        end
    endtask

    initial begin
        build_model();
        test_reset();
        @(negedge clk);
        test_lower_a();
        test_upper_a();
        test_backpressure();
        test_unmapped();
        test_ignore_busy();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
